// File: rtl/subpel_sad_ctrl.sv
// subpel_sad_ctrl
// ---------------------------------------------------------------------------
// Sequencer for the sub-pixel absolute-difference line datapath used in
// fractional motion estimation. It fetches BLK_H+2 reference rows and BLK_H
// original rows from 1-cycle-latency line memories and builds the 3-row
// window plus the org row for the datapath. It accumulates the 25 candidate
// SADs returned on diff_bus_i, then scans them for the minimum.
//
// Candidate index idx = 5*v + h, with v in {UH,UQ,M,LQ,LH} and h in
// {h,q,f,r,i}. The centre candidate M_f is idx 12.
//
// Optional build macro: SUBPEL_CENTER_BIAS_EN
//   defined   : the minimum search starts from idx 12, so ties go to the centre
//   undefined : the minimum search starts from idx 0, so ties go to the lowest idx
//
// Ports
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   start_i                 one-cycle request, sampled only in IDLE
//   ref_base_i, org_base_i  ref row -1 / org row 0 addresses, latched with start
//   busy_o, done_o          busy from the cycle after start through done;
//                           done is a one-cycle result-valid pulse
//   ref_rd_o/ref_addr_o     reference read strobe/address; ref_data_i follows 1 cycle later
//   org_rd_o/org_addr_o     original read strobe/address; org_data_i follows 1 cycle later
//   cur_*_pix_o, org_pix_o  window rows j-1, j, j+1 and org row j, to the datapath
//   diff_bus_i              25 packed 48-bit diff vectors (6 bytes each)
//   best_idx_o, best_sad_o  winning candidate and its SAD; held until next done
//   dbg_state_o             current FSM state encoding
//
// Handshake: start_i is accepted only when the FSM is in IDLE (busy_o low);
// done_o pulses for one cycle with best_idx_o/best_sad_o already valid, and
// the block is back in IDLE on the following cycle.
// ---------------------------------------------------------------------------
module subpel_sad_ctrl #(
  parameter int BLK_H = 8,
  parameter int AW    = 10,
  parameter int ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    ref_base_i,
  input  logic [AW-1:0]    org_base_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             ref_rd_o,
  output logic [AW-1:0]    ref_addr_o,
  input  logic [63:0]      ref_data_i,
  output logic             org_rd_o,
  output logic [AW-1:0]    org_addr_o,
  input  logic [63:0]      org_data_i,
  output logic [63:0]      cur_upper_pix_o,
  output logic [63:0]      cur_middle_pix_o,
  output logic [63:0]      cur_lower_pix_o,
  output logic [63:0]      org_pix_o,
  input  logic [1199:0]    diff_bus_i,
  output logic [4:0]       best_idx_o,
  output logic [ACC_W-1:0] best_sad_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_SELECT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [6:0]       LAST_K  = 7'(BLK_H + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  // Sum width wide enough for acc + 11-bit row sum without overflow.
  localparam int SW = ((ACC_W > 11) ? ACC_W : 11) + 1;

  state_t            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [AW-1:0]     ref_base_q, org_base_q;
  logic              ref_vld_q, org_vld_q, acc_vld_q;
  logic [63:0]       upper_q, middle_q, lower_q, org_q;
  logic [ACC_W-1:0]  acc_q [25];
  logic [ACC_W-1:0]  acc_nx [25];
  logic [10:0]       row_sum [25];
  logic [4:0]        run_idx_q, best_idx_q;
  logic [ACC_W-1:0]  run_sad_q, best_sad_q;
  logic              start_acc;

  // Selection datapath signals
  logic [ACC_W-1:0]  sel_acc, cmp_sad, new_sad;
  logic [4:0]        cmp_idx, new_idx;
  logic              sel_first, sel_win;

  function automatic logic [10:0] sum6(input logic [47:0] v);
    logic [10:0] s;
    s = '0;
    for (int b = 0; b < 6; b++) s = s + 11'(v[8*b +: 8]);
    return s;
  endfunction

  // Row sums and saturating accumulate candidates (combinational from diff_bus).
  always_comb begin
    for (int i = 0; i < 25; i++) begin
      logic [SW-1:0] s;
      row_sum[i] = sum6(diff_bus_i[48*i +: 48]);
      s = SW'(acc_q[i]) + SW'(row_sum[i]);
      acc_nx[i] = (s > SW'(ACC_MAX)) ? ACC_MAX : ACC_W'(s);
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    ref_rd_o   = 1'b0;
    ref_addr_o = '0;
    org_rd_o   = 1'b0;
    org_addr_o = '0;
    start_acc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = S_FETCH;
          cnt_d     = '0;
        end
      end
      S_FETCH: begin
        ref_rd_o   = 1'b1;
        ref_addr_o = ref_base_q + AW'(cnt_q);
        // Org rows trail the ref rows by two so org row j lands with window j.
        if (cnt_q >= 7'd2) begin
          org_rd_o   = 1'b1;
          org_addr_o = org_base_q + AW'(cnt_q - 7'd2);
        end
        if (cnt_q == LAST_K) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN: begin
        // Two cycles: last row returns, then last window is accumulated.
        if (cnt_q == 7'd1) begin
          state_d = S_SELECT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_SELECT: begin
        if (cnt_q == 7'd24) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Minimum scan, one candidate per SELECT cycle.
  always_comb begin
    sel_acc   = (cnt_q < 7'd25) ? acc_q[cnt_q[4:0]] : '0;
    sel_first = (cnt_q == 7'd0);
`ifdef SUBPEL_CENTER_BIAS_EN
    cmp_sad = sel_first ? acc_q[12] : run_sad_q;
    cmp_idx = sel_first ? 5'd12     : run_idx_q;
    sel_win = (sel_acc < cmp_sad);
`else
    cmp_sad = run_sad_q;
    cmp_idx = run_idx_q;
    sel_win = sel_first || (sel_acc < cmp_sad);
`endif
    new_sad = sel_win ? sel_acc : cmp_sad;
    new_idx = sel_win ? cnt_q[4:0] : cmp_idx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ref_base_q <= '0;
      org_base_q <= '0;
      ref_vld_q  <= 1'b0;
      org_vld_q  <= 1'b0;
      acc_vld_q  <= 1'b0;
      upper_q    <= '0;
      middle_q   <= '0;
      lower_q    <= '0;
      org_q      <= '0;
      run_idx_q  <= '0;
      run_sad_q  <= '0;
      best_idx_q <= '0;
      best_sad_q <= '0;
      for (int i = 0; i < 25; i++) acc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_vld_q <= ref_rd_o;
      org_vld_q <= org_rd_o;
      // Window for row j is complete one cycle after org row j returns.
      acc_vld_q <= org_vld_q;
      if (start_acc) begin
        ref_base_q <= ref_base_i;
        org_base_q <= org_base_i;
        for (int i = 0; i < 25; i++) acc_q[i] <= '0;
      end else if (acc_vld_q) begin
        for (int i = 0; i < 25; i++) acc_q[i] <= acc_nx[i];
      end
      if (ref_vld_q) begin
        upper_q  <= middle_q;
        middle_q <= lower_q;
        lower_q  <= ref_data_i;
      end
      if (org_vld_q) org_q <= org_data_i;
      if (state_q == S_SELECT) begin
        run_sad_q <= new_sad;
        run_idx_q <= new_idx;
        // Publish on the last candidate so results are valid alongside done.
        if (cnt_q == 7'd24) begin
          best_sad_q <= new_sad;
          best_idx_q <= new_idx;
        end
      end
    end
  end

  assign cur_upper_pix_o  = upper_q;
  assign cur_middle_pix_o = middle_q;
  assign cur_lower_pix_o  = lower_q;
  assign org_pix_o        = org_q;
  assign best_idx_o       = best_idx_q;
  assign best_sad_o       = best_sad_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/subpel_sad_ctrl.md
Name: subpel_sad_ctrl

Overview:
- Sequencer for the sub-pixel absolute-difference line datapath in fractional motion estimation.
- Fetches BLK_H+2 reference rows and BLK_H original rows (8 pixels each) from line memories and drives the datapath's 3-row window and org row.
- Accumulates the 25 candidate SADs over the block, scans for the minimum, and reports the winning candidate index and its SAD with a start/done handshake.

Parameters:
- BLK_H, 8, block height in rows. Range 1..64.
- AW, 10, line-memory address width.
- ACC_W, 16, SAD accumulator width. Accumulators saturate at all-ones.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- ref_base  in  AW  address of reference row -1 (the row above the block); sampled with start
- org_base  in  AW  address of original row 0; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result valid
- ref_rd  out  1  reference memory read strobe
- ref_addr  out  AW  reference read address
- ref_data  in  64  reference row; byte k is pixel k; valid the cycle after ref_rd
- org_rd  out  1  original memory read strobe
- org_addr  out  AW  original read address
- org_data  in  64  original row; valid the cycle after org_rd
- cur_upper_pix  out  64  window row j-1, to the datapath
- cur_middle_pix  out  64  window row j, to the datapath
- cur_lower_pix  out  64  window row j+1, to the datapath
- org_pix  out  64  original row j, to the datapath
- diff_bus  in  1200  25 packed 48-bit diff vectors from the datapath
- best_idx  out  5  winning candidate index, 0..24
- best_sad  out  ACC_W  winning SAD

Behaviour:
- Reset: all outputs, window and org registers, accumulators and counters go to 0. FSM returns to IDLE. rst asserted mid-operation aborts immediately with no done pulse.
- Candidate packing: idx = 5*v + h.
  - v order: UH, UQ, M, LQ, LH = 0..4.
  - h order: h, q, f, r, i = 0..4.
  - Candidate idx occupies diff_bus[48*idx +: 48], six unsigned 8-bit diffs. Centre candidate M_f = idx 12.
- Row sum: zero-extended sum of the 6 bytes, 11 bits. Accumulate: acc[idx] += row sum, saturating at 2^ACC_W-1.
- FSM states and transitions:
  - IDLE: on start, latch bases, clear accumulators, raise busy, go to FETCH. Start is sampled in cycle 0.
  - FETCH: counter k = 0..BLK_H+1, occupying cycles 1..BLK_H+2.
    - ref_rd=1, ref_addr=ref_base+k (addition wraps modulo 2^AW).
    - For k>=2: org_rd=1, org_addr=org_base+k-2.
  - Window shift: each cycle a ref row returns, upper<=middle, middle<=lower, lower<=ref_data. Returned org rows load org_pix.
  - Window valid: once the window holds rows j-1..j+1 and org row j, diff_bus is sampled and accumulated in that cycle, with no registering before the adders. Accumulation runs BLK_H times; the last one is captured at the end of cycle BLK_H+4.
  - DRAIN: waits out the read latency, then goes to SELECT.
  - SELECT: 25 cycles, one candidate per cycle, idx 0..24. Replace best when acc < best (strict).
  - DONE: done=1 for one cycle at cycle BLK_H+30; best_idx and best_sad are updated in the same cycle. busy drops with done; return to IDLE.
- best_idx and best_sad hold their values until the next done or reset.
- Window and org outputs hold their last values after the operation.
- start while busy is ignored. start in the same cycle as done's return to IDLE is accepted only from IDLE, on the next cycle.
- Memories have fixed 1-cycle latency with no backpressure.

Optional Feature:
- SUBPEL_CENTER_BIAS_EN
- Defined: SELECT initialises best from the centre, idx 12. All other candidates must be strictly smaller to win, so ties go to the centre. Latency is unchanged.
- Undefined: best initialises from idx 0, so ties go to the lowest index.

Test Plan:
- Reset and idle: after rst, all outputs are 0; with no start for 20 cycles, ref_rd, org_rd and done stay 0.
- Addressing, BLK_H=8, ref_base=0x100, org_base=0x040: ref_addr runs 0x100..0x109 on cycles 1..10. org_addr runs 0x040..0x047 on cycles 3..10. done falls on cycle 38.
- Minimum search: bench drives diff_bus with all bytes 1, except candidate 7 with all bytes 0 → best_idx=7, best_sad=0. Other accumulators equal 48.
- Ties: all bytes 2 → best_sad=96; best_idx=0 without the macro, 12 with it.
- Saturation, ACC_W=12, BLK_H=8, all bytes 0xFF: raw SAD 12240 → best_sad=4095, best_idx=0.
- Control: start pulsed mid-FETCH is ignored and the address sequence is unchanged. rst at cycle 5 gives no done and all outputs 0. A subsequent start completes normally with correct results.
